alu_input_capture: RTL and testbench

ALU_INPUT_CAPTURE -- requirements
Module: alu_input_capture

---
 rtl/alu_pkg.sv | 22 ++
 rtl/button_debounce.sv | 59 +++++
 rtl/alu_input_capture.sv | 112 +++++++++++
 tb/tb_alu_input_capture.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU input-capture block: button indices,
// debounce counter width and the collect/ready state encoding.
package alu_pkg;

  localparam int NUM_BTN = 3;
  localparam int BTN_A   = 2;
  localparam int BTN_B   = 1;
  localparam int BTN_OP  = 0;

  // Wide enough for DEBOUNCE_CYCLES up to 65535.
  localparam int DBC_W = 16;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_READY   = 1'b1
  } state_e;

  function automatic logic [1:0] count_ones3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One pushbutton: 2-flop synchroniser, then a stability counter that only
// moves the accepted level after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_async,
  output logic level,
  output logic rise
);

  localparam logic [DBC_W-1:0] CNT_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [DBC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_async;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    // Any sample matching the accepted level falls through with cnt_d = 0.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/alu_input_capture.sv
// Captures two operands and an opcode from a switch bank, one register per
// debounced pushbutton, and flags when all three have been loaded.
module alu_input_capture
  import alu_pkg::*;
#(
  parameter  int N_DATA          = 6,
  parameter  int N_OP            = 6,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int N_SW            = (N_DATA > N_OP) ? N_DATA : N_OP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_SW-1:0]    switches,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [N_DATA-1:0]  Data_A,
  output logic [N_DATA-1:0]  Data_B,
  output logic [N_OP-1:0]    Op,
  output logic [NUM_BTN-1:0] loaded,
  output logic               valid,
  output logic               update,
  output logic               err
);

  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .btn_async(buttons[gi]),
        .level    (btn_level[gi]),
        .rise     (btn_rise[gi])
      );
    end
  endgenerate

  logic [N_DATA-1:0]  data_a_q, data_a_d;
  logic [N_DATA-1:0]  data_b_q, data_b_d;
  logic [N_OP-1:0]    op_q, op_d;
  logic [NUM_BTN-1:0] loaded_q, loaded_d;
  logic               update_q, update_d;
  logic               err_q, err_d;
  logic               load_ok;
  state_e             state_q, state_d;

  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    op_d     = op_q;
    loaded_d = loaded_q;
    state_d  = state_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    load_ok  = 1'b0;

    // A rising button's own level is already high, so a lone clean press is
    // exactly one accepted level; anything more is a coincident or overlapped press.
    if (|btn_rise) begin
      if (count_ones3(btn_level) == 2'd1) begin
        load_ok = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (load_ok) begin
      if (btn_rise[BTN_A])  data_a_d = switches[N_DATA-1:0];
      if (btn_rise[BTN_B])  data_b_d = switches[N_DATA-1:0];
      if (btn_rise[BTN_OP]) op_d     = switches[N_OP-1:0];
      loaded_d = loaded_q | btn_rise;
      update_d = &loaded_d;
    end

    case (state_q)
      ST_COLLECT: if (&loaded_d) state_d = ST_READY;
      ST_READY:   state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      loaded_q <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= ST_COLLECT;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      loaded_q <= loaded_d;
      update_q <= update_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign Data_A = data_a_q;
  assign Data_B = data_b_q;
  assign Op     = op_q;
  assign loaded = loaded_q;
  assign valid  = (state_q == ST_READY);
  assign update = update_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_input_capture.sv
// Directed scenarios plus random button traffic against a window-based
// reference model of debounce, load arbitration and the ready flag.
module tb_alu_input_capture;

  localparam int D = 4;

  logic       clock;
  logic       reset;
  logic [5:0] switches;
  logic [2:0] buttons;
  logic [5:0] Data_A, Data_B, Op;
  logic [2:0] loaded;
  logic       valid, update, err;

  alu_input_capture #(
    .N_DATA         (6),
    .N_OP           (6),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .switches(switches),
    .buttons (buttons),
    .Data_A  (Data_A),
    .Data_B  (Data_B),
    .Op      (Op),
    .loaded  (loaded),
    .valid   (valid),
    .update  (update),
    .err     (err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state (as visible after the most recent rising edge)
  logic [5:0] m_a, m_b, m_op;
  logic [2:0] m_loaded, m_lvl, m_rise;
  logic       m_upd, m_err;
  logic [2:0] hist[$];

  // Per-phase observation counters
  int   upd_cnt, err_cnt, n_vrise;
  logic prev_valid, rise_upd;
  logic [5:0] rise_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Level flips once the D synchronised samples ending two edges ago all
  // disagree with it; a rising button loads on the next edge if it is alone.
  task automatic model_edge();
    logic [2:0] nlvl, nrise, others;
    int         nr, base;
    bit         all_diff, clash;
    if (reset) begin
      m_a = '0; m_b = '0; m_op = '0; m_loaded = '0;
      m_lvl = '0; m_rise = '0; m_upd = 1'b0; m_err = 1'b0;
      hist.push_back(3'b000);
    end else begin
      m_upd = 1'b0;
      m_err = 1'b0;
      nr = $countones(m_rise);
      if (nr > 0) begin
        clash = (nr >= 2);
        for (int b = 0; b < 3; b++) begin
          others = m_lvl & ~(3'b001 << b);
          if (m_rise[b] && others != 3'b000) clash = 1'b1;
        end
        if (clash) begin
          m_err = 1'b1;
        end else begin
          if (m_rise[2]) m_a  = switches;
          if (m_rise[1]) m_b  = switches;
          if (m_rise[0]) m_op = switches;
          m_loaded = m_loaded | m_rise;
          m_upd = (m_loaded == 3'b111);
        end
      end
      hist.push_back(buttons);
      nlvl = m_lvl;
      nrise = 3'b000;
      base = hist.size() - 2 - D;
      for (int b = 0; b < 3; b++) begin
        if (base >= 0) begin
          all_diff = 1'b1;
          for (int j = base; j < base + D; j++)
            if (hist[j][b] == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) begin
            nlvl[b]  = ~m_lvl[b];
            nrise[b] = nlvl[b];
          end
        end
      end
      m_lvl = nlvl;
      m_rise = nrise;
    end
  endtask

  task automatic check_all();
    chk("Data_A", {26'b0, Data_A}, {26'b0, m_a});
    chk("Data_B", {26'b0, Data_B}, {26'b0, m_b});
    chk("Op", {26'b0, Op}, {26'b0, m_op});
    chk("loaded", {29'b0, loaded}, {29'b0, m_loaded});
    chk("valid", {31'b0, valid}, {31'b0, (m_loaded == 3'b111)});
    chk("update", {31'b0, update}, {31'b0, m_upd});
    chk("err", {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
    if (update === 1'b1) upd_cnt++;
    if (err === 1'b1) err_cnt++;
    if (valid === 1'b1 && prev_valid !== 1'b1) begin
      n_vrise++;
      rise_upd = update;
      rise_op  = Op;
    end
    prev_valid = valid;
  endtask

  task automatic clear_counts();
    upd_cnt = 0;
    err_cnt = 0;
    n_vrise = 0;
  endtask

  task automatic press(input logic [2:0] b, input logic [5:0] sw, input int hold, input int gap);
    switches = sw;
    buttons = b;
    repeat (hold) cyc();
    buttons = 3'b000;
    repeat (gap) cyc();
  endtask

  initial begin
    logic [2:0] bsel;
    int r, hold, gap;
    clock = 1'b0;
    reset = 1'b1;
    buttons = 3'b000;
    switches = 6'h00;
    prev_valid = 1'b0;
    rise_upd = 1'b0;
    rise_op = 6'h00;
    clear_counts();

    repeat (3) cyc();
    chk("reset_loaded", {29'b0, loaded}, 32'h0);
    chk("reset_valid", {31'b0, valid}, 32'h0);
    reset = 1'b0;
    $display("step reset: loaded=%b valid=%b", loaded, valid);

    // Single load of A: new value exactly 7 edges after the press
    clear_counts();
    switches = 6'h15;
    buttons = 3'b100;
    repeat (6) cyc();
    chk("a_before_7", {26'b0, Data_A}, 32'h0);
    cyc();
    chk("a_at_7", {26'b0, Data_A}, 32'h15);
    chk("loaded_a", {29'b0, loaded}, 32'h4);
    repeat (3) cyc();
    buttons = 3'b000;
    repeat (10) cyc();
    chk("a_no_update", upd_cnt, 0);
    chk("a_no_err", err_cnt, 0);
    $display("step load_a: Data_A=%h loaded=%b", Data_A, loaded);

    // 3-cycle glitch on B is rejected
    press(3'b010, 6'h2A, 3, 10);
    chk("glitch_b", {26'b0, Data_B}, 32'h0);
    chk("glitch_loaded", {29'b0, loaded}, 32'h4);
    $display("step glitch_b: Data_B=%h loaded=%b", Data_B, loaded);

    // Coincident A+B press -> single err pulse, nothing loaded
    clear_counts();
    press(3'b110, 6'h33, 8, 10);
    chk("multi_err_cnt", err_cnt, 1);
    chk("multi_a", {26'b0, Data_A}, 32'h15);
    chk("multi_b", {26'b0, Data_B}, 32'h0);
    chk("multi_loaded", {29'b0, loaded}, 32'h4);
    $display("step multi: err_cnt=%0d loaded=%b", err_cnt, loaded);

    // Sequential A, B, Op -> valid rises with the Op load and one update
    clear_counts();
    press(3'b100, 6'h05, 10, 8);
    press(3'b010, 6'h03, 10, 8);
    chk("pre_op_valid", {31'b0, valid}, 32'h0);
    press(3'b001, 6'h20, 10, 8);
    chk("vrise_cnt", n_vrise, 1);
    chk("vrise_update", {31'b0, rise_upd}, 32'h1);
    chk("vrise_op", {26'b0, rise_op}, 32'h20);
    chk("seq_upd_cnt", upd_cnt, 1);
    chk("seq_a", {26'b0, Data_A}, 32'h05);
    chk("seq_b", {26'b0, Data_B}, 32'h03);
    $display("step sequence: A=%h B=%h Op=%h valid=%b", Data_A, Data_B, Op, valid);

    // Reload A in READY
    clear_counts();
    press(3'b100, 6'h3F, 10, 8);
    chk("reload_a", {26'b0, Data_A}, 32'h3F);
    chk("reload_upd_cnt", upd_cnt, 1);
    chk("reload_b", {26'b0, Data_B}, 32'h03);
    chk("reload_op", {26'b0, Op}, 32'h20);
    $display("step reload_a: A=%h update_cnt=%0d", Data_A, upd_cnt);

    // Reset mid-debounce while A is held, then full re-acceptance
    switches = 6'h0A;
    buttons = 3'b100;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    chk("rst_a", {26'b0, Data_A}, 32'h0);
    chk("rst_op", {26'b0, Op}, 32'h0);
    chk("rst_loaded", {29'b0, loaded}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    cyc();
    chk("rst_update", {31'b0, update}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    reset = 1'b0;
    repeat (6) cyc();
    chk("rst_a_before", {26'b0, Data_A}, 32'h0);
    cyc();
    chk("rst_a_load", {26'b0, Data_A}, 32'h0A);
    chk("rst_loaded_a", {29'b0, loaded}, 32'h4);
    buttons = 3'b000;
    repeat (8) cyc();
    $display("step reset_mid: Data_A=%h loaded=%b", Data_A, loaded);

    // Random traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6) bsel = 3'b001 << $urandom_range(0, 2);
      else bsel = 3'($urandom_range(1, 7));
      hold = $urandom_range(1, 10);
      gap = $urandom_range(1, 10);
      press(bsel, 6'($urandom), hold, gap);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
      end
      $display("txn %0d: buttons=%b hold=%0d gap=%0d A=%h B=%h Op=%h loaded=%b valid=%b",
               t, bsel, hold, gap, Data_A, Data_B, Op, loaded, valid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
